fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared sizing constants for the fifo_ctrl queue controller.
//   FIFO_AW    : default RAM address width
//   FIFO_DW    : default data width
//   FIFO_DEPTH : default number of entries (2**FIFO_AW)
package fifo_pkg;
  localparam int FIFO_AW    = 4;
  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl -- queue controller for a single-port distributed RAM that sits
// beside this module (synchronous write, asynchronous read).
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   enq_valid, enq_data   : producer offer
//   enq_ready             : enqueue accepted this cycle (combinational)
//   deq_req               : consumer asks for one word this cycle
//   deq_data, deq_valid   : registered dequeued word, one-cycle valid pulse
//   mem_a, mem_d, mem_we  : RAM address, write data, write enable
//   mem_spo               : RAM asynchronous read data at mem_a
//   count, full, empty    : occupancy 0..DEPTH and its flags
//   ovf, udf              : sticky error flags, only with FIFO_ERR_FLAGS_EN
//
// Handshake: an enqueue happens on a rising edge where enq_valid && enq_ready.
// enq_ready may drop while enq_valid is high (full, or a dequeue owns the RAM
// port); the producer then keeps enq_valid and enq_data stable until it sees
// enq_ready. A dequeue happens on an edge where deq_req && !empty; deq_req is
// a request, not a held handshake, and is ignored when empty.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN adds the ovf/udf outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW,
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  input  logic [DW-1:0] enq_data,
  output logic          enq_ready,
  input  logic          deq_req,
  output logic [DW-1:0] deq_data,
  output logic          deq_valid,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo,
`ifdef FIFO_ERR_FLAGS_EN
  output logic          ovf,
  output logic          udf,
`endif
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_deq;
  logic          do_enq;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // The RAM has one port, so a dequeue read and an enqueue write cannot
  // share a cycle; the dequeue wins. Both are suppressed while rst is high
  // so no write strobe escapes during reset.
  assign do_deq    = deq_req && !empty && !rst;
  assign do_enq    = enq_valid && !full && !do_deq && !rst;
  assign enq_ready = do_enq;

  // When idle the port points at head so mem_spo always shows the front.
  assign mem_a  = do_enq ? tail : head;
  assign mem_d  = enq_data;
  assign mem_we = do_enq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      deq_data  <= '0;
      deq_valid <= 1'b0;
    end else begin
      deq_valid <= do_deq;
      if (do_deq) begin
        deq_data <= mem_spo;
        head     <= head + 1'b1;
        count    <= count - 1'b1;
      end else if (do_enq) begin
        tail  <= tail + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (enq_valid && full) ovf <= 1'b1;
      if (deq_req && empty)  udf <= 1'b1;
    end
  end
`endif

endmodule
